csi2tx_vc_pkt_arbiter: RTL and testbench

CSI2TX_VC_PKT_ARBITER -- requirements
Module: csi2tx_vc_pkt_arbiter

---
 rtl/csi2tx_vc_pkt_arbiter_pkg.sv | 13 +
 rtl/csi2tx_rr_arbiter.sv | 29 ++
 rtl/csi2tx_vc_pkt_arbiter.sv | 177 +++++++++++++++++
 tb/tb_csi2tx_vc_pkt_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2tx_vc_pkt_arbiter_pkg.sv
// Shared constants for the CSI-2 TX virtual-channel packet arbiter:
// frame data types, the long-packet data-type threshold and FSM encodings.
package csi2tx_vc_pkt_arbiter_pkg;

  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] LONG_DT_MIN = 6'h10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/csi2tx_rr_arbiter.sv
// Combinational 4-way round-robin picker. Search starts at last_grant+1;
// lock_mask removes requesters that are not currently eligible.
module csi2tx_rr_arbiter (
  input  logic [3:0] req,
  input  logic [1:0] last_grant,
  input  logic [3:0] lock_mask,
  output logic [1:0] winner,
  output logic       any
);

  logic [3:0] masked;
  logic [1:0] idx;

  // First eligible requester after last_grant wins
  always_comb begin
    masked = req & lock_mask;
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = last_grant + 2'(i + 1);
      if (!any && masked[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/csi2tx_vc_pkt_arbiter.sv
// CSI-2 TX virtual-channel packet arbiter: grants one of four requesters
// per packet (header, then payload beats for long packets) in round-robin.
// Optional feature: define CSI2TX_ARB_FRAME_LOCK_EN to hold the grant on a
// requester between its Frame Start and Frame End short packets.
module csi2tx_vc_pkt_arbiter
  import csi2tx_vc_pkt_arbiter_pkg::*;
(
  input  logic         txbyteclkhs,
  input  logic         txbyteclkhs_rst_n,
  input  logic         forcetxstopmode,
  input  logic [3:0]   req_valid,
  input  logic [23:0]  req_dt,
  input  logic [63:0]  req_wc_df,
  input  logic [3:0]   req_data_valid,
  input  logic [255:0] req_data,
  output logic [3:0]   req_rdy,
  output logic [3:0]   req_data_rdy,
  output logic         packet_valid,
  output logic [5:0]   packet_dt,
  output logic [1:0]   packet_vc,
  output logic [15:0]  packet_wc_df,
  output logic         packet_data_valid,
  output logic [63:0]  packet_data,
  input  logic         packet_rdy,
  input  logic         packet_data_rdy,
  output logic [1:0]   grant_vc,
  output logic         arb_busy
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [13:0] cnt_q, cnt_d;

  logic [3:0]  lock_mask;
  logic [1:0]  arb_winner;
  logic        arb_any;
  logic        hdr_phase, data_phase;
  logic        hdr_hs, beat_hs, is_long;
  logic        sel_valid, sel_data_valid;
  logic [13:0] hdr_beats;

  csi2tx_rr_arbiter u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .lock_mask  (lock_mask),
    .winner     (arb_winner),
    .any        (arb_any)
  );

  // Field mux on the current grant; forcetxstopmode kills every valid/rdy
  always_comb begin
    packet_dt      = '0;
    packet_wc_df   = '0;
    packet_data    = '0;
    sel_valid      = 1'b0;
    sel_data_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (grant_q == 2'(i)) begin
        packet_dt      = req_dt[6*i +: 6];
        packet_wc_df   = req_wc_df[16*i +: 16];
        packet_data    = req_data[64*i +: 64];
        sel_valid      = req_valid[i];
        sel_data_valid = req_data_valid[i];
      end
    end
    hdr_phase         = (state_q == ST_HDR)  && !forcetxstopmode;
    data_phase        = (state_q == ST_DATA) && !forcetxstopmode;
    packet_valid      = hdr_phase && sel_valid;
    packet_data_valid = data_phase && sel_data_valid;
    req_rdy           = hdr_phase  ? ({3'b000, packet_rdy} << grant_q)      : 4'b0000;
    req_data_rdy      = data_phase ? ({3'b000, packet_data_rdy} << grant_q) : 4'b0000;
    hdr_hs            = packet_valid && packet_rdy;
    beat_hs           = packet_data_valid && packet_data_rdy;
    is_long           = (packet_dt >= LONG_DT_MIN) && (packet_wc_df != 16'd0);
    // ceil(wc/8) without a 17-bit add: floor plus one if any remainder bit set
    hdr_beats         = {1'b0, packet_wc_df[15:3]} + {13'd0, |packet_wc_df[2:0]};
  end

  assign packet_vc = grant_q;
  assign grant_vc  = grant_q;
  assign arb_busy  = (state_q != ST_IDLE);

  // Packet FSM: arbitrate in IDLE, hold grant through header and payload
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    if (forcetxstopmode) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            grant_d = arb_winner;
            state_d = ST_HDR;
          end
        end
        ST_HDR: begin
          if (hdr_hs) begin
            if (is_long) begin
              state_d = ST_DATA;
              cnt_d   = hdr_beats;
            end else begin
              state_d      = ST_IDLE;
              last_grant_d = grant_q;
            end
          end
        end
        ST_DATA: begin
          if (beat_hs) begin
            cnt_d = cnt_q - 14'd1;
            if (cnt_q == 14'd1) begin
              state_d      = ST_IDLE;
              last_grant_d = grant_q;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM, grant and beat counter registers
  always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
    if (!txbyteclkhs_rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= 2'd3;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef CSI2TX_ARB_FRAME_LOCK_EN
  logic       lock_q, lock_d;
  logic [1:0] lock_vc_q, lock_vc_d;

  // Frame lock: set on a completed FS, released by the same requester's FE
  always_comb begin
    lock_d    = lock_q;
    lock_vc_d = lock_vc_q;
    if (forcetxstopmode) begin
      lock_d = 1'b0;
    end else if (hdr_hs && !is_long) begin
      if (packet_dt == DT_FS) begin
        lock_d    = 1'b1;
        lock_vc_d = grant_q;
      end else if ((packet_dt == DT_FE) && lock_q && (grant_q == lock_vc_q)) begin
        lock_d = 1'b0;
      end
    end
  end

  // Frame lock registers
  always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
    if (!txbyteclkhs_rst_n) begin
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_vc_q <= lock_vc_d;
    end
  end

  assign lock_mask = lock_q ? (4'b0001 << lock_vc_q) : 4'b1111;
`else
  assign lock_mask = 4'b1111;
`endif

endmodule

// File: tb/tb_csi2tx_vc_pkt_arbiter.sv
// Self-checking bench for csi2tx_vc_pkt_arbiter. Expected headers and
// payload beats are queued when stimulus is set up and popped by a monitor
// on every observed handshake. Frame-lock scenario runs only when
// CSI2TX_ARB_FRAME_LOCK_EN is defined.
module tb_csi2tx_vc_pkt_arbiter;

  logic         txbyteclkhs = 1'b0;
  logic         txbyteclkhs_rst_n;
  logic         forcetxstopmode;
  logic [3:0]   req_valid;
  logic [23:0]  req_dt;
  logic [63:0]  req_wc_df;
  logic [3:0]   req_data_valid;
  logic [255:0] req_data;
  logic [3:0]   req_rdy;
  logic [3:0]   req_data_rdy;
  logic         packet_valid;
  logic [5:0]   packet_dt;
  logic [1:0]   packet_vc;
  logic [15:0]  packet_wc_df;
  logic         packet_data_valid;
  logic [63:0]  packet_data;
  logic         packet_rdy;
  logic         packet_data_rdy;
  logic [1:0]   grant_vc;
  logic         arb_busy;

  csi2tx_vc_pkt_arbiter dut (
    .txbyteclkhs       (txbyteclkhs),
    .txbyteclkhs_rst_n (txbyteclkhs_rst_n),
    .forcetxstopmode   (forcetxstopmode),
    .req_valid         (req_valid),
    .req_dt            (req_dt),
    .req_wc_df         (req_wc_df),
    .req_data_valid    (req_data_valid),
    .req_data          (req_data),
    .req_rdy           (req_rdy),
    .req_data_rdy      (req_data_rdy),
    .packet_valid      (packet_valid),
    .packet_dt         (packet_dt),
    .packet_vc         (packet_vc),
    .packet_wc_df      (packet_wc_df),
    .packet_data_valid (packet_data_valid),
    .packet_data       (packet_data),
    .packet_rdy        (packet_rdy),
    .packet_data_rdy   (packet_data_rdy),
    .grant_vc          (grant_vc),
    .arb_busy          (arb_busy)
  );

  always #5 txbyteclkhs = ~txbyteclkhs;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [23:0] hdr_q[$];
  logic [63:0] dat_q[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    return {vc, dt, wc};
  endfunction

  task automatic set_hdr(input int i, input logic [5:0] dt, input logic [15:0] wc);
    req_dt[6*i +: 6]     = dt;
    req_wc_df[16*i +: 16] = wc;
  endtask

  task automatic tick();
    @(posedge txbyteclkhs);
    #1;
  endtask

  // Bounded wait for the next header phase
  task automatic wait_hdr(input string tag);
    int n = 0;
    @(negedge txbyteclkhs);
    while (!packet_valid && n < 20) begin
      @(negedge txbyteclkhs);
      n++;
    end
    check_eq(tag, 64'(packet_valid), 64'd1);
  endtask

  // Scoreboard monitor: every handshake must match the next queued item
  always @(negedge txbyteclkhs) begin
    if (txbyteclkhs_rst_n) begin
      if (packet_valid && packet_rdy) begin
        if (hdr_q.size() == 0) check_eq("hdr_extra", 64'(hdr_q.size()), 64'd1);
        else check_eq("hdr", 64'({packet_vc, packet_dt, packet_wc_df}), 64'(hdr_q.pop_front()));
      end
      if (packet_data_valid && packet_data_rdy) begin
        if (dat_q.size() == 0) check_eq("beat_extra", 64'(dat_q.size()), 64'd1);
        else check_eq("beat", packet_data, dat_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [3:0]  pat;
  int unsigned acc;

  initial begin
    txbyteclkhs_rst_n = 1'b0;
    forcetxstopmode   = 1'b0;
    req_valid         = '0;
    req_dt            = '0;
    req_wc_df         = '0;
    req_data_valid    = '0;
    req_data          = '0;
    packet_rdy        = 1'b1;
    packet_data_rdy   = 1'b0;
    for (int i = 0; i < 4; i++) set_hdr(i, 6'h08 + 6'(i), 16'h0100 * 16'(i) + 16'd3);

    // Reset state
    repeat (3) @(negedge txbyteclkhs);
    check_eq("rst_busy",  64'(arb_busy), 64'd0);
    check_eq("rst_grant", 64'(grant_vc), 64'd0);
    check_eq("rst_vc",    64'(packet_vc), 64'd0);
    check_eq("rst_pv",    64'(packet_valid), 64'd0);
    check_eq("rst_pdv",   64'(packet_data_valid), 64'd0);
    check_eq("rst_rdy",   64'(req_rdy), 64'd0);
    check_eq("rst_drdy",  64'(req_data_rdy), 64'd0);
    tick();
    txbyteclkhs_rst_n = 1'b1;

    // Round robin across four short-packet requesters: 0,1,2,3,0 with gaps
    for (int k = 0; k < 5; k++)
      hdr_q.push_back(hdr(2'(k % 4), 6'h08 + 6'(k % 4), 16'h0100 * 16'(k % 4) + 16'd3));
    tick();
    req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      @(negedge txbyteclkhs);
      check_eq("rr_pv",   64'(packet_valid), 64'(k % 2));
      check_eq("rr_busy", 64'(arb_busy), 64'(k % 2));
    end
    tick();
    req_valid = '0;

    // Long packet wc=20 from requester 2, data ready pattern 1,0,1,1
    set_hdr(2, 6'h2A, 16'd20);
    hdr_q.push_back(hdr(2'd2, 6'h2A, 16'd20));
    for (int b = 0; b < 3; b++) dat_q.push_back(64'hD00D_0000_0000_0000 + 64'(b));
    req_data_valid = 4'b0100;
    req_data[128 +: 64] = 64'hD00D_0000_0000_0000;
    req_valid = 4'b0100;
    wait_hdr("long_hdr");
    check_eq("long_hdr_rdy", 64'(req_rdy), 64'b0100);
    tick();
    req_valid = '0;
    pat = 4'b1101;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      packet_data_rdy = pat[c];
      req_data[128 +: 64] = 64'hD00D_0000_0000_0000 + 64'(acc);
      @(negedge txbyteclkhs);
      check_eq("beat_pdv",  64'(packet_data_valid), 64'd1);
      check_eq("beat_vc",   64'(packet_vc), 64'd2);
      check_eq("beat_drdy", 64'(req_data_rdy), pat[c] ? 64'b0100 : 64'd0);
      tick();
      if (pat[c]) acc++;
    end
    packet_data_rdy = 1'b0;
    req_data_valid  = '0;
    @(negedge txbyteclkhs);
    check_eq("long_done_busy", 64'(arb_busy), 64'd0);
    check_eq("long_beats_left", 64'(dat_q.size()), 64'd0);

    // Long data type with wc=0 is header-only
    set_hdr(3, 6'h20, 16'd0);
    hdr_q.push_back(hdr(2'd3, 6'h20, 16'd0));
    packet_data_rdy = 1'b1;
    req_data_valid  = 4'b1000;
    req_valid       = 4'b1000;
    wait_hdr("wc0_hdr");
    check_eq("hdr_no_drdy", 64'(req_data_rdy), 64'd0);
    check_eq("hdr_no_pdv",  64'(packet_data_valid), 64'd0);
    tick();
    req_valid = '0;
    @(negedge txbyteclkhs);
    check_eq("wc0_idle", 64'(arb_busy), 64'd0);
    check_eq("wc0_pdv",  64'(packet_data_valid), 64'd0);
    packet_data_rdy = 1'b0;
    req_data_valid  = '0;

    // forcetxstopmode mid-DATA (5 beats outstanding)
    set_hdr(0, 6'h2B, 16'd40);
    hdr_q.push_back(hdr(2'd0, 6'h2B, 16'd40));
    req_data_valid = 4'b0001;
    req_valid      = 4'b0001;
    wait_hdr("stop_hdr");
    tick();
    req_valid = '0;
    @(negedge txbyteclkhs);
    check_eq("stop_in_data", 64'(packet_data_valid), 64'd1);
    tick();
    forcetxstopmode = 1'b1;
    packet_data_rdy = 1'b1;
    @(negedge txbyteclkhs);
    check_eq("stop_pdv",  64'(packet_data_valid), 64'd0);
    check_eq("stop_drdy", 64'(req_data_rdy), 64'd0);
    check_eq("stop_rdy",  64'(req_rdy), 64'd0);
    tick();
    forcetxstopmode = 1'b0;
    packet_data_rdy = 1'b0;
    @(negedge txbyteclkhs);
    check_eq("stop_idle", 64'(arb_busy), 64'd0);
    check_eq("stop_idle_drdy", 64'(req_data_rdy), 64'd0);
    set_hdr(0, 6'h08, 16'd3);
    hdr_q.push_back(hdr(2'd0, 6'h08, 16'd3));
    req_valid = 4'b0011;
    wait_hdr("post_stop");
    check_eq("post_stop_vc", 64'(packet_vc), 64'd0);
    tick();
    req_valid      = '0;
    req_data_valid = '0;

`ifdef CSI2TX_ARB_FRAME_LOCK_EN
    // Frame lock: requester 1 holds the grant from FS to FE
    set_hdr(1, 6'h00, 16'd0);
    set_hdr(3, 6'h0B, 16'h0303);
    hdr_q.push_back(hdr(2'd1, 6'h00, 16'd0));
    hdr_q.push_back(hdr(2'd1, 6'h02, 16'd5));
    hdr_q.push_back(hdr(2'd1, 6'h01, 16'd0));
    hdr_q.push_back(hdr(2'd3, 6'h0B, 16'h0303));
    req_valid = 4'b1011;
    wait_hdr("fs_hdr");
    check_eq("fs_vc", 64'(packet_vc), 64'd1);
    tick();
    set_hdr(1, 6'h02, 16'd5);
    wait_hdr("lock_hdr");
    check_eq("lock_vc", 64'(packet_vc), 64'd1);
    tick();
    set_hdr(1, 6'h01, 16'd0);
    wait_hdr("fe_hdr");
    check_eq("fe_vc", 64'(packet_vc), 64'd1);
    tick();
    req_valid = 4'b1001;
    wait_hdr("after_fe");
    check_eq("after_fe_vc", 64'(packet_vc), 64'd3);
    tick();
    req_valid = '0;
`endif

    // Asynchronous reset in the middle of a header
    packet_rdy = 1'b0;
    set_hdr(2, 6'h0A, 16'd7);
    req_valid = 4'b0100;
    wait_hdr("pre_rst");
    check_eq("pre_rst_vc", 64'(grant_vc), 64'd2);
    #2;
    txbyteclkhs_rst_n = 1'b0;
    #1;
    check_eq("arst_pv",    64'(packet_valid), 64'd0);
    check_eq("arst_busy",  64'(arb_busy), 64'd0);
    check_eq("arst_grant", 64'(grant_vc), 64'd0);
    check_eq("arst_vc",    64'(packet_vc), 64'd0);
    req_valid = '0;
    tick();
    txbyteclkhs_rst_n = 1'b1;
    packet_rdy = 1'b1;
    hdr_q.push_back(hdr(2'd0, 6'h08, 16'd3));
    req_valid = 4'b0101;
    wait_hdr("post_rst");
    check_eq("post_rst_vc", 64'(packet_vc), 64'd0);
    tick();
    req_valid = '0;
    repeat (3) @(negedge txbyteclkhs);

    check_eq("hdr_q_empty", 64'(hdr_q.size()), 64'd0);
    check_eq("dat_q_empty", 64'(dat_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
